// File: rtl/cga_mode_sequencer.sv
// Mode sequencer for the CGA-style timing generator: holds one of three H/V timing presets
// and swaps them only at frame boundaries. Optional watchdog macro: CGA_MODE_TIMEOUT_EN.
module cga_mode_sequencer #(
    parameter int unsigned DEFAULT_MODE   = 0,
    parameter int unsigned LOAD_CYCLES    = 16,
    parameter int unsigned SETTLE_FRAMES  = 2
`ifdef CGA_MODE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
`endif
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_mode,
    output logic        req_ready,
    output logic        req_err,
    input  logic        vs_in,
    output logic        gen_rst_n,
    output logic [10:0] h_front,
    output logic [10:0] h_sync,
    output logic [10:0] h_back,
    output logic [10:0] h_act,
    output logic [10:0] v_front,
    output logic [10:0] v_sync,
    output logic [10:0] v_back,
    output logic [10:0] v_act,
    output logic [1:0]  cur_mode,
    output logic        video_en,
    output logic        switch_done
);
    localparam int unsigned      LoadW      = $clog2(LOAD_CYCLES);
    localparam logic [LoadW-1:0] LoadLast   = LoadW'(LOAD_CYCLES - 1);
    localparam logic [3:0]       SettleLast = 4'(SETTLE_FRAMES - 1);
    localparam logic [1:0]       DefMode    = 2'(DEFAULT_MODE);

    typedef enum logic [1:0] {StLoad, StSettle, StRun, StWait} state_e;

    // Packed as {h_front, h_sync, h_back, h_act, v_front, v_sync, v_back, v_act}.
    function automatic logic [87:0] preset_timing(input logic [1:0] mode);
        case (mode)
            2'd1:    return {11'd10, 11'd135, 11'd17, 11'd720, 11'd2, 11'd16, 11'd2, 11'd350};
            2'd2:    return {11'd14, 11'd60, 11'd30, 11'd640, 11'd1, 11'd2, 11'd11, 11'd350};
            default: return {11'd27, 11'd57, 11'd81, 11'd640, 11'd20, 11'd3, 11'd40, 11'd200};
        endcase
    endfunction

    state_e           state_q;
    logic [1:0]       cur_mode_q;
    logic [1:0]       pend_mode_q;
    logic [87:0]      timing_q;
    logic             gen_rst_n_q;
    logic             video_en_q;
    logic             req_ready_q;
    logic             req_err_q;
    logic             switch_done_q;
    logic [LoadW-1:0] load_cnt_q;
    logic [3:0]       frame_cnt_q;
    logic             from_reset_q;
    logic             vs_q;

    logic vs_rise;
    logic tmo_hit;
    logic wait_go;
    logic settle_done;

    assign vs_rise     = vs_in & ~vs_q;
    assign wait_go     = (state_q == StWait) && (vs_rise || tmo_hit);
    assign settle_done = (state_q == StSettle) &&
                         ((vs_rise && (frame_cnt_q == SettleLast)) || tmo_hit);

`ifdef CGA_MODE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            tmo_flag_q;

    // Per-frame watchdog: restarts on every vs_rise and whenever it fires.
    assign tmo_hit = ((state_q == StWait) || (state_q == StSettle)) &&
                     (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (((state_q == StWait) || (state_q == StSettle)) && !vs_rise && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StLoad;
            cur_mode_q    <= DefMode;
            pend_mode_q   <= DefMode;
            timing_q      <= preset_timing(DefMode);
            gen_rst_n_q   <= 1'b0;
            video_en_q    <= 1'b0;
            req_ready_q   <= 1'b0;
            req_err_q     <= 1'b0;
            switch_done_q <= 1'b0;
            load_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            from_reset_q  <= 1'b1;
            vs_q          <= 1'b0;
`ifdef CGA_MODE_TIMEOUT_EN
            tmo_flag_q    <= 1'b0;
`endif
        end else begin
            vs_q          <= vs_in;
            req_err_q     <= 1'b0;
            switch_done_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (req_valid && req_ready_q) begin
                        if (req_mode == 2'd3) begin
                            req_err_q <= 1'b1;
                        end else if (req_mode == cur_mode_q) begin
                            switch_done_q <= 1'b1;
                        end else begin
                            pend_mode_q <= req_mode;
                            req_ready_q <= 1'b0;
                            state_q     <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (wait_go) begin
                        cur_mode_q   <= pend_mode_q;
                        timing_q     <= preset_timing(pend_mode_q);
                        gen_rst_n_q  <= 1'b0;
                        video_en_q   <= 1'b0;
                        load_cnt_q   <= '0;
                        from_reset_q <= 1'b0;
                        state_q      <= StLoad;
`ifdef CGA_MODE_TIMEOUT_EN
                        tmo_flag_q   <= !vs_rise;
`endif
                    end
                end
                StLoad: begin
                    // vs_rise is ignored here: the generator is held in reset.
                    if (load_cnt_q == LoadLast) begin
                        load_cnt_q  <= '0;
                        frame_cnt_q <= '0;
                        gen_rst_n_q <= 1'b1;
                        state_q     <= StSettle;
                    end else begin
                        load_cnt_q <= load_cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (settle_done) begin
                        frame_cnt_q   <= '0;
                        video_en_q    <= 1'b1;
                        req_ready_q   <= 1'b1;
                        switch_done_q <= !from_reset_q;
                        from_reset_q  <= 1'b0;
                        state_q       <= StRun;
`ifdef CGA_MODE_TIMEOUT_EN
                        req_err_q     <= tmo_flag_q;
                        tmo_flag_q    <= 1'b0;
`endif
                    end else if (vs_rise) begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign {h_front, h_sync, h_back, h_act, v_front, v_sync, v_back, v_act} = timing_q;

    assign req_ready   = req_ready_q;
    assign req_err     = req_err_q;
    assign gen_rst_n   = gen_rst_n_q;
    assign cur_mode    = cur_mode_q;
    assign video_en    = video_en_q;
    assign switch_done = switch_done_q;

endmodule
